// File: rtl/half_adder.sv
// Combinational half adder: one-bit sum and carry of two input bits.
module half_adder (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);

   // Sum is the parity of the inputs; carry is set only when both are 1.
   always_comb begin
      sum   = a ^ b;
      carry = a & b;
   end

endmodule

// File: rtl/fa_using_half_addar.sv
// Registered one-bit full adder built from two cascaded half adders.
// {Y1,Y2} holds A+B+C from the previous rising edge; synchronous active-low reset.
module fa_using_half_addar (
   input  logic clk,
   input  logic rst_n,
   output logic Y2,
   output logic Y1,
   input  logic A,
   input  logic B,
   input  logic C
);

   logic s1;
   logic c1;
   logic s2;
   logic c2;
   logic sum_d;
   logic carry_d;

   // First stage adds the two addend bits.
   half_adder u_ha1 (
      .a     (A),
      .b     (B),
      .sum   (s1),
      .carry (c1)
   );

   // Second stage folds in the carry-in.
   half_adder u_ha2 (
      .a     (s1),
      .b     (C),
      .sum   (s2),
      .carry (c2)
   );

   // Carry-out is set if either stage generated a carry; they cannot both be 1.
   always_comb begin
      sum_d   = s2;
      carry_d = c1 | c2;
   end

   // Output registers; reset wins over the computed result on the same edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         Y1 <= 1'b0;
         Y2 <= 1'b0;
      end else begin
         Y1 <= carry_d;
         Y2 <= sum_d;
      end
   end

endmodule

// File: tb/tb_fa_using_half_addar.sv
// Scoreboard bench for fa_using_half_addar: the stimulus pushes expected {Y1,Y2},
// and the monitor pops and checks one entry after each rising edge.
module tb_fa_using_half_addar;

   logic clk;
   logic rst_n;
   logic Y2;
   logic Y1;
   logic A;
   logic B;
   logic C;

   typedef struct {
      string      name;
      logic [1:0] exp;
   } exp_t;

   exp_t q[$];
   int   n_cmp;
   int   n_err;

   fa_using_half_addar dut (
      .clk   (clk),
      .rst_n (rst_n),
      .Y2    (Y2),
      .Y1    (Y1),
      .A     (A),
      .B     (B),
      .C     (C)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got {Y1,Y2}=%b, expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: on each rising edge with a pending expectation, check just after the
   // edge and again late in the cycle to confirm the outputs held.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check(e.name, {Y1, Y2}, e.exp);
            #3;
            check({e.name, "_hold"}, {Y1, Y2}, e.exp);
         end
      end
   end

   // Drive one vector on the falling edge and queue its expected result.
   task automatic apply(input string name, input logic r, input logic a, input logic b,
                        input logic c, input logic [1:0] exp);
      @(negedge clk);
      rst_n = r;
      A     = a;
      B     = b;
      C     = c;
      q.push_back('{name: name, exp: exp});
   endtask

   // Hand-computed vectors: reset, then ABC in order 000,010,001,011,100,110,101,111.
   logic [2:0] vec_abc [8];
   logic [1:0] vec_exp [8];

   initial begin
      int unsigned r;
      logic [1:0]  m;
      int          wait_cnt;

      vec_abc = '{3'b000, 3'b010, 3'b001, 3'b011, 3'b100, 3'b110, 3'b101, 3'b111};
      vec_exp = '{2'd0,   2'd1,   2'd1,   2'd2,   2'd1,   2'd2,   2'd2,   2'd3};
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      A = 1'b1;
      B = 1'b1;
      C = 1'b1;

      // Reset held for two edges with all inputs high.
      apply("reset0", 1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
      apply("reset1", 1'b0, 1'b1, 1'b1, 1'b1, 2'd0);

      // Truth table; first vector lands on the first edge after release.
      for (int i = 0; i < 8; i++) begin
         apply($sformatf("tt_%b", vec_abc[i]), 1'b1, vec_abc[i][2], vec_abc[i][1],
               vec_abc[i][0], vec_exp[i]);
      end

      // Reset on the same edge as A=1,B=1,C=0, then release.
      apply("rst_override", 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
      apply("rst_release", 1'b1, 1'b1, 1'b1, 1'b0, 2'd2);

      // Glitch on A between edges must not reach the outputs.
      @(negedge clk);
      A = 1'b0;
      B = 1'b0;
      C = 1'b0;
      q.push_back('{name: "a_glitch", exp: 2'd0});
      #1 A = 1'b1;
      #2 A = 1'b0;

      // Reset pulse between edges is ignored.
      @(negedge clk);
      A = 1'b1;
      B = 1'b1;
      C = 1'b1;
      q.push_back('{name: "rst_glitch", exp: 2'd3});
      #1 rst_n = 1'b0;
      #2 rst_n = 1'b1;

      // Random run against the arithmetic model.
      for (int i = 0; i < 220; i++) begin
         r = $urandom_range(0, 7);
         m = 2'(r[0]) + 2'(r[1]) + 2'(r[2]);
         apply("random", 1'b1, r[2], r[1], r[0], m);
      end

      // Drain the scoreboard with a bounded wait.
      wait_cnt = 0;
      while (q.size() > 0 && wait_cnt < 20) begin
         @(posedge clk);
         wait_cnt++;
      end
      #6;
      if (q.size() > 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
